data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Load/store sequencer between the core's memory stage and the word-organised data RAM. Accepts byte, halfword and word requests at byte addresses, extracts and sign/zero-extends load data, and performs read-modify-write for sub-word stores, because the RAM writes whole words only and reads 0 while its write enable is high. Stalls the core through `o_busy` while a request is in flight.

## Interface
- `DATA_WIDTH`, 32: word width; only 32 is supported.
- `ADDR_WIDTH`, 6: RAM word-address width; the byte address is `ADDR_WIDTH+2` bits.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  request strobe; sampled only in IDLE.
- `i_we`  in  1  1 = store, 0 = load.
- `i_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `i_sign`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `i_addr`  in  ADDR_WIDTH+2  byte address.
- `i_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `o_rdata`  out  32  registered, extended load result.
- `o_done`  out  1  one-cycle pulse when a request completes.
- `o_misalign`  out  1  one-cycle pulse, coincident with `o_done`, for a rejected request.
- `o_busy`  out  1  high whenever state is not IDLE.
- `o_ram_addr`  out  ADDR_WIDTH  word address, equal to latched `addr[ADDR_WIDTH+1:2]`.
- `o_ram_wdata`  out  32  merged write word.
- `o_ram_we`  out  1  RAM write enable.
- `i_ram_rdata`  in  32  combinational RAM read data.

## Operation
- Byte lanes are little-endian. `addr[1:0]=k` selects bits `[8k+7:8k]`. A halfword at `addr[1]=h` selects bits `[16h+15:16h]`.
- States:
  - IDLE
  - LD: read cycle.
  - RD: RMW read cycle.
  - WR: write cycle.
- **Acceptance.** In IDLE with `i_req=1`, all request inputs are latched.
- **Misalignment check.** A request is misaligned if:
  - the size is halfword and `addr[0]=1`, or
  - the size is word and `addr[1:0]≠0`, or
  - the size is 11.
  
  A misaligned request raises `o_misalign` and `o_done` for the next cycle. State stays IDLE, there is no RAM write, and `o_rdata` is unchanged.
- **Transitions from IDLE on an aligned request:**
  - Load goes to LD.
  - Word store goes to WR.
  - Byte or halfword store goes to RD.
- **LD.** `o_ram_we=0`. At the clock edge, the selected lane of `i_ram_rdata` is extended into `o_rdata` (word loads are taken as-is). `o_done` is set and the next state is IDLE.
- **RD.** `o_ram_we=0`. At the clock edge, `i_ram_rdata` is captured into the merge register and the next state is WR.
- **WR.** `o_ram_we=1`. `o_ram_wdata` is one of:
  - the latched word (word store), or
  - the merge register with the target lane(s) replaced by `i_wdata[7:0]` or `[15:0]`.
  
  At the clock edge, `o_done` is set and the next state is IDLE.
- `i_req` outside IDLE is ignored. Request inputs may change freely after acceptance.
- `o_ram_we`, `o_ram_addr` and `o_ram_wdata` are decoded combinationally from state and latched registers.
- **Reset values:** state IDLE; `o_rdata=0`; `o_done=0`; `o_misalign=0`; `o_busy=0`; `o_ram_we=0`; `o_ram_addr=0`; `o_ram_wdata=0`; all latches 0.
- **Reset asserted in RD or WR:** `o_ram_we` drops immediately and the store is abandoned with no partial write. `o_done` does not pulse.

## Timing
Request sampled at edge E0:
- Misaligned: `o_done` and `o_misalign` are high from E0 to E1.
- Load: LD lasts E0–E1. `o_rdata` is valid and `o_done` is high from E1 to E2.
- Word store: WR lasts E0–E1 and the RAM writes at E1. `o_done` is high from E1 to E2.
- Sub-word store: RD lasts E0–E1, WR lasts E1–E2, and the RAM writes at E2. `o_done` is high from E2 to E3.

Throughput:
- The next request may be sampled at the edge that ends the `o_done` cycle (state is IDLE and `o_busy=0` during that cycle).
- Back-to-back loads: one per 2 cycles.

## Structure
- Shared package `mem_pkg` holds:
  - size codes `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the state encoding;
  - `WORD_BYTES=4`.
- Sub-module `byte_lane_unit` is purely combinational and shared by both paths:
  - load extraction and extension: inputs are word, `addr[1:0]`, size and sign;
  - store merge: inputs are old word, new data, `addr[1:0]` and size.
- The top level holds the FSM, the latches and the registered outputs.

## Test plan
- **Word round trip.** Store word `0xDEADBEEF` at byte address `0x08`, then load word at `0x08`.
  - Store: RAM word 2 is written at E1 and `o_done` pulses.
  - Load: `o_rdata=0xDEADBEEF` one cycle after acceptance.
- **Byte RMW.** RAM word 2 holds `0x11223344`. Store byte `0xAA` at `0x09`.
  - RD then WR, with `o_ram_wdata=0x1122AA44` in WR.
  - `o_busy` is high for 2 cycles.
- **Extension.** RAM word 3 holds `0x80F07F01`.
  - Signed byte load at `0x0E` gives `0xFFFFFFF0`.
  - Unsigned halfword load at `0x0E` gives `0x000080F0`.
  - Signed halfword load at `0x0C` gives `0x00007F01`.
- **Misalignment.** For each of: halfword at `0x05`, word at `0x06`, size 11:
  - `o_misalign` and `o_done` pulse one cycle after acceptance;
  - `o_ram_we` never rises and `o_rdata` is unchanged.
- **Reset mid-store.** Assert `i_rst_n=0` during WR of a byte store.
  - `o_ram_we` goes low immediately and the RAM word is unchanged.
  - All outputs hold reset values and `o_done` does not pulse.
- **Busy/ignore.** Hold `i_req=1` with changing inputs through a sub-word store.
  - Only the first request executes.
  - The next request is accepted at the edge ending the `o_done` cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared size codes, FSM encoding and alignment helper for the data memory path
package mem_pkg;
  localparam int WORD_BYTES = 4;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_LD, ST_RD, ST_WR} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return size == SZ_HALF ? lo[0] : size == SZ_WORD ? |lo : size != SZ_BYTE;
  endfunction
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: little-endian lane extraction/extension for loads and lane merge for stores
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [8*WORD_BYTES-1:0] ld_word,
  input  logic [1:0]              lane,
  input  logic [1:0]              size,
  input  logic                    sign,
  output logic [8*WORD_BYTES-1:0] ld_data,
  input  logic [8*WORD_BYTES-1:0] st_old,
  input  logic [8*WORD_BYTES-1:0] st_new,
  output logic [8*WORD_BYTES-1:0] st_word
);
  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  logic [31:0] data;
  // byte shift places lane k at bit 8k; halfwords only ever sit at bit 0 or 16
  always_comb begin
    bsh = {lane, 3'b000};
    hsh = {lane[1], 4'b0000};
    b = 8'(ld_word >> bsh);
    h = lane[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = size == SZ_BYTE ? {{24{sign & b[7]}}, b} : size == SZ_HALF ? {{16{sign & h[15]}}, h} : ld_word;
    mask = size == SZ_BYTE ? 32'h0000_00ff << bsh : 32'h0000_ffff << hsh;
    data = size == SZ_BYTE ? {24'b0, st_new[7:0]} << bsh : {16'b0, st_new[15:0]} << hsh;
    st_word = size == SZ_WORD ? st_new : (st_old & ~mask) | (data & mask);
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store sequencer with read-modify-write for sub-word stores to a word RAM
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_sign,
  input  logic [ADDR_WIDTH+1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_done,
  output logic                  o_misalign,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);
  state_t                state, state_d;
  logic                  we_q, sign_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, merge_q, ld_data, st_word;
  logic                  acc, bad;
  byte_lane_unit u_lane (
    .ld_word(i_ram_rdata),
    .lane   (addr_q[1:0]),
    .size   (size_q),
    .sign   (sign_q),
    .ld_data(ld_data),
    .st_old (merge_q),
    .st_new (wdata_q),
    .st_word(st_word)
  );
  // next state: aligned requests leave IDLE, RD always feeds WR, LD/WR return to IDLE
  always_comb begin
    acc = state == ST_IDLE && i_req;
    bad = misaligned(i_size, i_addr[1:0]);
    state_d = acc && !bad ? (!i_we ? ST_LD : i_size == SZ_WORD ? ST_WR : ST_RD) : state == ST_RD ? ST_WR : ST_IDLE;
  end
  // state register; reset abandons any store in flight
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= ST_IDLE;
    else state <= state_d;
  // request latches, merge register and registered completion outputs
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      we_q <= 1'b0;
      sign_q <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      o_rdata <= '0;
      o_done <= 1'b0;
      o_misalign <= 1'b0;
    end else begin
      o_done <= (acc && bad) || state == ST_LD || state == ST_WR;
      o_misalign <= acc && bad;
      if (acc) begin
        we_q <= i_we;
        sign_q <= i_sign;
        size_q <= i_size;
        addr_q <= i_addr;
        wdata_q <= i_wdata;
      end
      if (state == ST_LD) o_rdata <= ld_data;
      if (state == ST_RD) merge_q <= i_ram_rdata;
    end
  // RAM side is decoded straight from state and latches
  always_comb begin
    o_busy = state != ST_IDLE;
    o_ram_we = state == ST_WR && we_q;
    o_ram_addr = addr_q[ADDR_WIDTH+1:2];
    o_ram_wdata = st_word;
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench with a RAM model and a byte-level reference memory
module tb_data_mem_ctrl;
  logic        i_clk = 0, i_rst_n = 0, i_req = 0, i_we = 0, i_sign = 0;
  logic [1:0]  i_size = 0;
  logic [7:0]  i_addr = 0;
  logic [31:0] i_wdata = 0, o_rdata, o_ram_wdata, i_ram_rdata;
  logic        o_done, o_misalign, o_busy, o_ram_we;
  logic [5:0]  o_ram_addr;
  logic [31:0] ram [64];
  logic [7:0]  ref_b [256];
  logic [31:0] last_rdata = 0;
  int          n_cmp = 0, n_err = 0;
  typedef struct {logic [31:0] rdata; logic mis; logic st; int lat; int busy;} exp_t;
  exp_t sb [$];

  data_mem_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_sign(i_sign), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_done(o_done),
    .o_misalign(o_misalign), .o_busy(o_busy), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .o_ram_we(o_ram_we), .i_ram_rdata(i_ram_rdata)
  );

  always #5 i_clk = ~i_clk;
  assign i_ram_rdata = o_ram_we ? 32'h0 : ram[o_ram_addr];
  always @(posedge i_clk) if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return size == 2'b00 ? 1 : size == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [5:0] w);
    return {ref_b[{w, 2'd3}], ref_b[{w, 2'd2}], ref_b[{w, 2'd1}], ref_b[{w, 2'd0}]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sign, input logic [7:0] a);
    logic [31:0] v = 0;
    int n = nbytes(size);
    for (int i = 0; i < n; i++) v[8*i+:8] = ref_b[a + 8'(i)];
    if (sign && n < 4 && v[8*n-1]) for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [7:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(size); i++) ref_b[a + 8'(i)] = d[8*i+:8];
  endtask

  task automatic run(input logic we, input logic [1:0] size, input logic sign, input logic [7:0] a,
                     input logic [31:0] d, input logic hold);
    exp_t e;
    int k, busy;
    logic seen_we;
    logic [31:0] cap;
    e.mis = size == 2'b11 || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
    e.st = we && !e.mis;
    e.lat = e.mis ? 0 : (e.st && size != 2'b10) ? 2 : 1;
    e.busy = e.mis ? 0 : e.lat;
    e.rdata = (!we && !e.mis) ? ref_load(size, sign, a) : last_rdata;
    last_rdata = e.rdata;
    if (e.st) ref_store(size, a, d);
    sb.push_back(e);
    i_req = 1; i_we = we; i_size = size; i_sign = sign; i_addr = a; i_wdata = d;
    @(posedge i_clk);
    k = 0; busy = 0; seen_we = 0; cap = 0;
    forever begin
      @(negedge i_clk);
      if (!hold) i_req = 0;
      else begin i_we = 1; i_size = 2'b10; i_addr = 8'h20; i_wdata = $urandom; end
      if (o_ram_we) begin seen_we = 1; cap = o_ram_wdata; end
      busy += int'(o_busy);
      if (o_done || k == 8) break;
      k++;
    end
    e = sb.pop_front();
    chk("done", 32'(o_done), 32'(1));
    chk("latency", 32'(k), 32'(e.lat));
    chk("misalign", 32'(o_misalign), 32'(e.mis));
    chk("rdata", o_rdata, e.rdata);
    chk("busy_cycles", 32'(busy), 32'(e.busy));
    chk("ram_we_seen", 32'(seen_we), 32'(e.st));
    if (e.st) begin
      chk("ram_wdata", cap, ref_word(a[7:2]));
      chk("ram_word", ram[a[7:2]], ref_word(a[7:2]));
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 0;
    for (int i = 0; i < 256; i++) ref_b[i] = 0;
    repeat (2) @(negedge i_clk);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_mis", 32'(o_misalign), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_we", 32'(o_ram_we), 0);
    chk("rst_addr", 32'(o_ram_addr), 0);
    chk("rst_wdata", o_ram_wdata, 0);
    i_rst_n = 1;
    @(negedge i_clk);
    run(1, 2'b10, 0, 8'h08, 32'hDEADBEEF, 0);
    run(0, 2'b10, 0, 8'h08, 0, 0);
    chk("word_rt", o_rdata, 32'hDEADBEEF);
    run(1, 2'b10, 0, 8'h08, 32'h11223344, 0);
    run(1, 2'b00, 0, 8'h09, 32'hFFFF55AA, 0);
    chk("byte_rmw", ram[2], 32'h1122AA44);
    run(1, 2'b10, 0, 8'h0C, 32'h80F07F01, 0);
    run(0, 2'b00, 1, 8'h0E, 0, 0);
    chk("sbyte", o_rdata, 32'hFFFFFFF0);
    run(0, 2'b01, 0, 8'h0E, 0, 0);
    chk("uhalf", o_rdata, 32'h000080F0);
    run(0, 2'b01, 1, 8'h0C, 0, 0);
    chk("shalf", o_rdata, 32'h00007F01);
    run(0, 2'b01, 1, 8'h0E, 0, 0);
    run(0, 2'b00, 0, 8'h0F, 0, 0);
    run(0, 2'b01, 0, 8'h05, 0, 0);
    run(1, 2'b10, 0, 8'h06, 32'h12345678, 0);
    run(0, 2'b11, 0, 8'h00, 0, 0);
    run(1, 2'b11, 0, 8'h0C, 32'hCAFEF00D, 0);
    run(1, 2'b01, 0, 8'h0E, 32'h0000BEEF, 0);
    run(1, 2'b00, 0, 8'h0F, 32'h00000099, 0);
    run(0, 2'b10, 0, 8'h0C, 0, 0);
    i_req = 1; i_we = 1; i_size = 2'b00; i_sign = 0; i_addr = 8'h09; i_wdata = 32'h55;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req = 0;
    chk("rst_rd_busy", 32'(o_busy), 1);
    @(negedge i_clk);
    chk("rst_wr_we", 32'(o_ram_we), 1);
    i_rst_n = 0;
    #1;
    chk("rst_we_drop", 32'(o_ram_we), 0);
    chk("rst_busy2", 32'(o_busy), 0);
    chk("rst_rdata2", o_rdata, 0);
    chk("rst_ramaddr2", 32'(o_ram_addr), 0);
    chk("rst_ramwdata2", o_ram_wdata, 0);
    @(negedge i_clk);
    chk("rst_done2", 32'(o_done), 0);
    chk("rst_ram_kept", ram[2], ref_word(6'd2));
    i_rst_n = 1;
    last_rdata = 0;
    @(negedge i_clk);
    chk("rst_no_done", 32'(o_done), 0);
    run(1, 2'b01, 0, 8'h0E, 32'h00001234, 1);
    run(0, 2'b10, 0, 8'h0C, 0, 0);
    chk("ignored_req", ram[8], ref_word(6'd8));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
